// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//   APB control/status slave and loop sequencer for the matmul engine.
//   Software programs the N/K/M dimensions in CTRL and writes START. The block
//   snapshots the dimensions and walks every output element C[i][j] through
//   one accumulator clear, K MAC steps and one writeback. It ends with a
//   one-cycle DONE state that sets the sticky DONE flag in STATUS.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   psel_i .. paddr_i       APB slave inputs (byte address, byte-lane strobes)
//   pready_o, pslverr_o     APB response (zero wait states)
//   prdata_o                APB read data, 0 outside a read access phase
//   busy_o                  sequence in progress (every state except IDLE)
//   mac_clr_o/mac_en_o/wb_en_o  datapath strobes, mutually exclusive
//   idx_i_o/idx_j_o/idx_k_o loop indices, held at 0 while idle
//
// Register map (dimension fields hold dimension-1)
//   0x00 CTRL   [0] START (W1 pulse), [1] ABORT (W1 pulse), both read 0
//               [IW+7:8] N-1, [IW+15:16] K-1, [IW+23:24] M-1
//   0x04 STATUS [0] busy (RO), [1] DONE (W1C)
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = 4,
  localparam int IW        = $clog2(MAX_DIM),
  localparam int SW        = BUS_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [SW-1:0]         pstrb_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  busy_o,
  output logic                  mac_clr_o,
  output logic                  mac_en_o,
  output logic                  wb_en_o,
  output logic [IW-1:0]         idx_i_o,
  output logic [IW-1:0]         idx_j_o,
  output logic [IW-1:0]         idx_k_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_WB, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] dim_n, dim_k, dim_m;   // programmed fields (dimension-1)
  logic [IW-1:0] run_n, run_k, run_m;   // snapshot used by the running sequence
  logic          done_flag;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic access, wr_access, rd_access;
  logic sel_ctrl, sel_status, addr_err, start_err;
  logic wr_ok, ctrl_we, status_we;
  logic start_go, abort_go, done_clr;
  logic [IW-1:0] n_nxt, k_nxt, m_nxt;

  assign access    = psel_i & penable_i;
  assign wr_access = access & pwrite_i;
  assign rd_access = access & ~pwrite_i;

  assign sel_ctrl   = (paddr_i == ADDR_WIDTH'(0));
  assign sel_status = (paddr_i == ADDR_WIDTH'(4));
  assign addr_err   = ~(sel_ctrl | sel_status);
  // START only counts when its byte lane is strobed; a rejected START blocks
  // the whole write, dimension lanes included.
  assign start_err  = wr_access & sel_ctrl & pstrb_i[0] & pwdata_i[0] & busy_o;

  assign pready_o  = access;
  assign pslverr_o = access & (addr_err | start_err);

  assign wr_ok     = wr_access & ~addr_err & ~start_err;
  assign ctrl_we   = wr_ok & sel_ctrl;
  assign status_we = wr_ok & sel_status;

  assign start_go = ctrl_we & pstrb_i[0] & pwdata_i[0];
  assign abort_go = ctrl_we & pstrb_i[0] & pwdata_i[1];
  assign done_clr = status_we & pstrb_i[0] & pwdata_i[1];

  // Dimension values as they will be after this cycle's write, so a single
  // CTRL write can both program the dimensions and start the sequence.
  assign n_nxt = (ctrl_we && pstrb_i[1]) ? pwdata_i[8  +: IW] : dim_n;
  assign k_nxt = (ctrl_we && pstrb_i[2]) ? pwdata_i[16 +: IW] : dim_k;
  assign m_nxt = (ctrl_we && pstrb_i[3]) ? pwdata_i[24 +: IW] : dim_m;

  // Upper data bits and extra strobe lanes carry no register state.
  logic unused_bits;
  assign unused_bits = ^{pwdata_i, pstrb_i};

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // paths that skip the assignment infer a latch.
  always_comb begin
    prdata_o = '0;
    if (rd_access) begin
      if (sel_ctrl) begin
        prdata_o[8  +: IW] = dim_n;
        prdata_o[16 +: IW] = dim_k;
        prdata_o[24 +: IW] = dim_m;
      end else if (sel_status) begin
        prdata_o[0] = busy_o;
        prdata_o[1] = done_flag;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dim_n <= '0;
      dim_k <= '0;
      dim_m <= '0;
    end else begin
      dim_n <= n_nxt;
      dim_k <= k_nxt;
      dim_m <= m_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: all outputs are registered and set on the transition into the
  // state that owns them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      mac_clr_o <= 1'b0;
      mac_en_o  <= 1'b0;
      wb_en_o   <= 1'b0;
      idx_i_o   <= '0;
      idx_j_o   <= '0;
      idx_k_o   <= '0;
      run_n     <= '0;
      run_k     <= '0;
      run_m     <= '0;
      done_flag <= 1'b0;
    end else begin
      mac_clr_o <= 1'b0;
      mac_en_o  <= 1'b0;
      wb_en_o   <= 1'b0;

      // The DONE-state set below comes later in the block, so it overrides a
      // W1C landing in the same cycle.
      if (done_clr) done_flag <= 1'b0;

      if (abort_go && state != S_IDLE) begin
        state   <= S_IDLE;
        busy_o  <= 1'b0;
        idx_i_o <= '0;
        idx_j_o <= '0;
        idx_k_o <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_go) begin
              run_n     <= n_nxt;
              run_k     <= k_nxt;
              run_m     <= m_nxt;
              state     <= S_CLR;
              busy_o    <= 1'b1;
              mac_clr_o <= 1'b1;
            end
          end
          S_CLR: begin
            state    <= S_MAC;
            mac_en_o <= 1'b1;
          end
          S_MAC: begin
            if (idx_k_o == run_k) begin
              state   <= S_WB;
              wb_en_o <= 1'b1;
              idx_k_o <= '0;
            end else begin
              idx_k_o  <= idx_k_o + IW'(1);
              mac_en_o <= 1'b1;
            end
          end
          S_WB: begin
            if (idx_j_o != run_m) begin
              idx_j_o   <= idx_j_o + IW'(1);
              state     <= S_CLR;
              mac_clr_o <= 1'b1;
            end else begin
              idx_j_o <= '0;
              if (idx_i_o != run_n) begin
                idx_i_o   <= idx_i_o + IW'(1);
                state     <= S_CLR;
                mac_clr_o <= 1'b1;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            done_flag <= 1'b1;
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            idx_i_o   <= '0;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//   Self-checking bench for matmul_seq_ctrl. A negedge monitor records every
//   cycle in which the sequencer shows activity; each scenario compares that
//   record against a list of expected cycles produced by nested loops over
//   the matrix element order.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

  localparam int BW = 32;
  localparam int AW = 16;
  localparam int IW = 2;

  typedef logic [9:0] obs_t;  // {busy, clr, mac, wb, i, j, k}

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [3:0]    pstrb_i = '0;
  logic [BW-1:0] pwdata_i = '0;
  logic [AW-1:0] paddr_i = '0;
  logic          pready_o, pslverr_o;
  logic [BW-1:0] prdata_o;
  logic          busy_o, mac_clr_o, mac_en_o, wb_en_o;
  logic [IW-1:0] idx_i_o, idx_j_o, idx_k_o;

  int total = 0;
  int bad   = 0;

  obs_t obs_q[$];
  obs_t exp_q[$];

  matmul_seq_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .pstrb_i(pstrb_i), .pwdata_i(pwdata_i), .paddr_i(paddr_i),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .prdata_o(prdata_o),
    .busy_o(busy_o), .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o),
    .wb_en_o(wb_en_o), .idx_i_o(idx_i_o), .idx_j_o(idx_j_o), .idx_k_o(idx_k_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t cur_obs();
    return {busy_o, mac_clr_o, mac_en_o, wb_en_o, idx_i_o, idx_j_o, idx_k_o};
  endfunction

  always @(negedge clk_i)
    if (!rst_i && cur_obs() != '0) obs_q.push_back(cur_obs());

  // Reference: element order i outer, j inner; per element clear, K MACs,
  // writeback; then one DONE cycle with j already wrapped to 0.
  function automatic void build_model(int n, int k, int m);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        exp_q.push_back({4'b1100, 2'(i), 2'(j), 2'(0)});
        for (int kk = 0; kk < k; kk++)
          exp_q.push_back({4'b1010, 2'(i), 2'(j), 2'(kk)});
        exp_q.push_back({4'b1001, 2'(i), 2'(j), 2'(0)});
      end
    exp_q.push_back({4'b1000, 2'(n - 1), 2'(0), 2'(0)});
  endfunction

  function automatic logic [31:0] ctrl_word(int n, int k, int m, bit start, bit abort);
    logic [31:0] w;
    w = '0;
    w[0] = start;
    w[1] = abort;
    w[9:8]   = 2'(n - 1);
    w[17:16] = 2'(k - 1);
    w[25:24] = 2'(m - 1);
    return w;
  endfunction

  // Setup phase on one negedge, access phase on the next; the access edge is
  // the following posedge. Returns 1 time unit after that edge.
  task automatic apb(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rd, output logic err,
                     output logic rdy);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1;
    rd = prdata_o; err = pslverr_o; rdy = pready_o;
    @(posedge clk_i);
    #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy_o && c < 300) begin
      @(negedge clk_i);
      c++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout: busy=%b want 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, rdy;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    total++;
    if ({cur_obs(), pready_o, pslverr_o, prdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got obs=%h rdy=%b err=%b rd=%h want all 0",
               cur_obs(), pready_o, pslverr_o, prdata_o);
    end
    apb(1'b0, 16'h0, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if ({rd, err, rdy} !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_ctrl: got rd=%h err=%b rdy=%b want 0/0/1", rd, err, rdy);
    end
    apb(1'b0, 16'h4, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_status: got %h want 0", rd);
    end
  endtask

  // Full run with given dims: sequence, busy length, DONE flag, then W1C.
  task automatic test_run(input int n, input int k, input int m, input string name);
    logic [31:0] rd; logic err, rdy;
    build_model(n, k, m);
    obs_q.delete();
    apb(1'b1, 16'h0, ctrl_word(n, k, m, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    wait_idle(name);
    total++;
    if (obs_q.size() != n * m * (k + 2) + 1) begin
      bad++;
      $display("FAIL %s busy_len: got %0d want %0d", name, obs_q.size(), n * m * (k + 2) + 1);
    end
    for (int c = 0; c < exp_q.size() && c < obs_q.size(); c++) begin
      total++;
      if (obs_q[c] !== exp_q[c]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c + 1, obs_q[c], exp_q[c]);
      end
    end
    apb(1'b0, 16'h4, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL %s status: got %h want 2", name, rd);
    end
    apb(1'b1, 16'h4, 32'h2, 4'h1, rd, err, rdy);
  endtask

  task automatic test_random_runs();
    for (int t = 0; t < 8; t++)
      test_run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), "random_run");
  endtask

  task automatic test_start_while_busy();
    logic [31:0] rd; logic err, rdy;
    build_model(2, 3, 2);
    obs_q.delete();
    apb(1'b1, 16'h0, ctrl_word(2, 3, 2, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    apb(1'b1, 16'h0, ctrl_word(4, 4, 4, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    total++;
    if ({err, rdy} !== 2'b11) begin
      bad++;
      $display("FAIL start_busy_err: got err=%b rdy=%b want 1/1", err, rdy);
    end
    apb(1'b0, 16'h0, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if ({rd, err} !== {ctrl_word(2, 3, 2, 1'b0, 1'b0), 1'b0}) begin
      bad++;
      $display("FAIL start_busy_nochange: got %h err=%b want %h", rd, err,
               ctrl_word(2, 3, 2, 1'b0, 1'b0));
    end
    apb(1'b1, 16'h0, ctrl_word(1, 1, 1, 1'b0, 1'b0), 4'hF, rd, err, rdy);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL dim_write_busy_err: got %b want 0", err);
    end
    wait_idle("start_busy");
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL start_busy_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int c = 0; c < exp_q.size() && c < obs_q.size(); c++) begin
      total++;
      if (obs_q[c] !== exp_q[c]) begin
        bad++;
        $display("FAIL start_busy cycle %0d: got %b want %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    apb(1'b0, 16'h0, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== ctrl_word(1, 1, 1, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL dim_write_busy_kept: got %h want %h", rd, ctrl_word(1, 1, 1, 1'b0, 1'b0));
    end
    apb(1'b0, 16'h8, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if ({rd, err} !== {32'h0, 1'b1}) begin
      bad++;
      $display("FAIL unmapped_read: got rd=%h err=%b want 0/1", rd, err);
    end
    apb(1'b1, 16'h4, 32'h2, 4'h1, rd, err, rdy);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err, rdy;
    build_model(2, 3, 2);
    obs_q.delete();
    apb(1'b1, 16'h0, ctrl_word(2, 3, 2, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    repeat (2) @(negedge clk_i);
    // Access edge lands at the end of cycle 4 (CLR, MAC0, MAC1, MAC2).
    apb(1'b1, 16'h0, 32'h2, 4'h1, rd, err, rdy);
    @(negedge clk_i);
    total++;
    if (cur_obs() !== '0) begin
      bad++;
      $display("FAIL abort_next: got %b want 0", cur_obs());
    end
    repeat (8) @(negedge clk_i);
    total++;
    if (obs_q.size() != 4) begin
      bad++;
      $display("FAIL abort_len: got %0d want 4", obs_q.size());
    end
    for (int c = 0; c < 4 && c < obs_q.size(); c++) begin
      total++;
      if (obs_q[c] !== exp_q[c]) begin
        bad++;
        $display("FAIL abort cycle %0d: got %b want %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    apb(1'b0, 16'h4, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL abort_status: got %h want 0", rd);
    end
    obs_q.delete();
    apb(1'b1, 16'h0, 32'h2, 4'h1, rd, err, rdy);
    repeat (3) @(negedge clk_i);
    total++;
    if ({obs_q.size(), err} != {32'd0, 1'b0}) begin
      bad++;
      $display("FAIL abort_idle: got activity=%0d err=%b want 0/0", obs_q.size(), err);
    end
  endtask

  task automatic test_done_w1c();
    logic [31:0] rd; logic err, rdy;
    int n, k, m, b;
    n = $urandom_range(1, 3); k = $urandom_range(1, 3); m = $urandom_range(1, 3);
    b = n * m * (k + 2) + 1;
    apb(1'b1, 16'h0, ctrl_word(n, k, m, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    repeat (b - 2) @(negedge clk_i);
    // Access edge lands at the end of the DONE cycle.
    apb(1'b1, 16'h4, 32'h2, 4'h1, rd, err, rdy);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL done_w1c_idle: busy=%b want 0", busy_o);
    end
    apb(1'b0, 16'h4, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL done_set_wins: got %h want 2", rd);
    end
    apb(1'b1, 16'h4, 32'h2, 4'h1, rd, err, rdy);
    apb(1'b0, 16'h4, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL done_w1c: got %h want 0", rd);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd; logic err, rdy;
    apb(1'b1, 16'h0, ctrl_word(2, 3, 2, 1'b1, 1'b0), 4'hF, rd, err, rdy);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    obs_q.delete();
    @(negedge clk_i);
    total++;
    if (cur_obs() !== '0) begin
      bad++;
      $display("FAIL reset_mid_run: got %b want 0", cur_obs());
    end
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL reset_no_wb: got %0d active cycles want 0", obs_q.size());
    end
    apb(1'b0, 16'h0, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_dims: got %h want 0", rd);
    end
    obs_q.delete();
    apb(1'b1, 16'h0, ctrl_word(3, 2, 4, 1'b1, 1'b0), 4'b1110, rd, err, rdy);
    repeat (3) @(negedge clk_i);
    total++;
    if ({obs_q.size(), err} != {32'd0, 1'b0}) begin
      bad++;
      $display("FAIL strobe_no_start: got activity=%0d err=%b want 0/0", obs_q.size(), err);
    end
    apb(1'b0, 16'h0, 32'h0, 4'h0, rd, err, rdy);
    total++;
    if (rd !== ctrl_word(3, 2, 4, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL strobe_dims: got %h want %h", rd, ctrl_word(3, 2, 4, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_run(1, 2, 1, "run_1x2x1");
    test_run(2, 3, 2, "run_2x3x2");
    test_run(4, 4, 4, "run_4x4x4");
    test_random_runs();
    test_start_while_busy();
    test_abort();
    test_done_w1c();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
